// File: rtl/mcb_pkg.sv
// Shared types and constants for the multi-colour bounding-box video stage.
package mcb_pkg;
  localparam int COORD_W = 16;
  localparam logic [3:0] VIDEO = 4'h0;

  // Per-colour register offsets within each 4-word block
  localparam logic [1:0] MIN   = 2'd0;
  localparam logic [1:0] MAX   = 2'd1;
  localparam logic [1:0] BOX_X = 2'd2;
  localparam logic [1:0] BOX_Y = 2'd3;
  // Offsets from word 4*NUM_COLOURS
  localparam int STATUS  = 0;
  localparam int OVERLAY = 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic in_window(rgb_t p, rgb_t lo, rgb_t hi);
    return (p.r >= lo.r) && (p.r <= hi.r) &&
           (p.g >= lo.g) && (p.g <= hi.g) &&
           (p.b >= lo.b) && (p.b <= hi.b);
  endfunction
endpackage

// File: rtl/colour_bbox_tracker.sv
// One colour tracker: shadowed RGB thresholds, match compare, live and latched box.
module colour_bbox_tracker
  import mcb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_min_i,
  input  logic               wr_max_i,
  input  logic [23:0]        wdata_i,
  input  logic               frame_start_i,
  input  logic               pix_vld_i,
  input  rgb_t               pix_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic               latch_i,
  output logic               match_o,
  output logic [23:0]        pend_min_o,
  output logic [23:0]        pend_max_o,
  output logic [31:0]        box_x_o,
  output logic [31:0]        box_y_o,
  output logic               hit_o
);
  rgb_t               pend_min_q, pend_max_q, act_min_q, act_max_q;
  logic               seen_q, seen_d;
  logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [COORD_W-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
  logic [31:0]        box_x_q, box_y_q;
  logic               hit_q;

  assign match_o = pix_vld_i & in_window(pix_i, act_min_q, act_max_q);

  // Next live box includes the current beat so an EOP pixel is seen by the latch
  always_comb begin
    seen_d = seen_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (frame_start_i) begin
      seen_d = 1'b0;
    end else if (match_o) begin
      seen_d = 1'b1;
      if (!seen_q) begin
        xmin_d = x_i;
        xmax_d = x_i;
        ymin_d = y_i;
        ymax_d = y_i;
      end else begin
        if (x_i < xmin_q) xmin_d = x_i;
        if (x_i > xmax_q) xmax_d = x_i;
        if (y_i < ymin_q) ymin_d = y_i;
        if (y_i > ymax_q) ymax_d = y_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_min_q <= '0;
      pend_max_q <= '1;
      act_min_q  <= '0;
      act_max_q  <= '1;
      seen_q     <= 1'b0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      box_x_q    <= '0;
      box_y_q    <= '0;
      hit_q      <= 1'b0;
    end else begin
      if (wr_min_i) pend_min_q <= wdata_i;
      if (wr_max_i) pend_max_q <= wdata_i;
      if (frame_start_i) begin
        act_min_q <= pend_min_q;
        act_max_q <= pend_max_q;
      end
      seen_q <= seen_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      if (latch_i) begin
        hit_q   <= seen_d;
        box_x_q <= seen_d ? {xmax_d, xmin_d} : '0;
        box_y_q <= seen_d ? {ymax_d, ymin_d} : '0;
      end
    end
  end

  assign pend_min_o = pend_min_q;
  assign pend_max_o = pend_max_q;
  assign box_x_o    = box_x_q;
  assign box_y_o    = box_y_q;
  assign hit_o      = hit_q;
endmodule

// File: rtl/multi_colour_bbox.sv
// Avalon-ST video stage tracking per-colour bounding boxes, with optional overlay
// recolouring and an Avalon-MM register window.
module multi_colour_bbox
  import mcb_pkg::*;
#(
  parameter int NUM_COLOURS = 4,
  parameter int IMAGE_W     = 640,
  parameter int IMAGE_H     = 480,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode,
  input  logic [23:0]       sink_data,
  input  logic              sink_valid,
  input  logic              sink_sop,
  input  logic              sink_eop,
  output logic              sink_ready,
  output logic [23:0]       source_data,
  output logic              source_valid,
  output logic              source_sop,
  output logic              source_eop,
  input  logic              source_ready,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata
);
  logic [23:0]          src_data_q, src_data_d;
  logic                 src_valid_q, src_sop_q, src_eop_q;
  logic                 vid_pkt_q, mode_q;
  logic [COORD_W-1:0]   x_q, y_q, x_d, y_d;
  logic [23:0]          ovl_pend_q, ovl_act_q;
  logic [15:0]          frame_cnt_q;
  logic [31:0]          rdata_q, rdata_d;
  logic [7:0]           status;
  logic                 accept, is_video_hdr, frame_start, body, pix_vld, latch;
  logic [NUM_COLOURS-1:0] match, hit, wr_min, wr_max;
  logic [23:0]          pend_min [NUM_COLOURS];
  logic [23:0]          pend_max [NUM_COLOURS];
  logic [31:0]          box_x    [NUM_COLOURS];
  logic [31:0]          box_y    [NUM_COLOURS];
  logic                 unused_wdata;

  assign unused_wdata = ^s_writedata[31:24];

  assign sink_ready   = source_ready | ~src_valid_q;
  assign accept       = sink_valid & sink_ready;
  assign is_video_hdr = (sink_data[3:0] == VIDEO);
  assign frame_start  = accept & sink_sop & is_video_hdr;
  assign body         = accept & ~sink_sop & vid_pkt_q;
  assign pix_vld      = body & (y_q < COORD_W'(IMAGE_H));
  assign latch        = body & sink_eop;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_start) begin
      x_d = '0;
      y_d = '0;
    end else if (body) begin
      if (x_q == COORD_W'(IMAGE_W - 1)) begin
        x_d = '0;
        if (y_q < COORD_W'(IMAGE_H)) y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // match[] is already gated to in-frame video pixels, so headers pass untouched
  assign src_data_d = (mode_q && (|match)) ? ovl_act_q : sink_data;

  for (genvar g = 0; g < NUM_COLOURS; g++) begin : g_trk
    assign wr_min[g] = s_write && (s_address == ADDR_W'(4 * g + int'(MIN)));
    assign wr_max[g] = s_write && (s_address == ADDR_W'(4 * g + int'(MAX)));
    colour_bbox_tracker u_trk (
      .clk          (clk),
      .rst_n        (reset_n),
      .wr_min_i     (wr_min[g]),
      .wr_max_i     (wr_max[g]),
      .wdata_i      (s_writedata[23:0]),
      .frame_start_i(frame_start),
      .pix_vld_i    (pix_vld),
      .pix_i        (rgb_t'(sink_data)),
      .x_i          (x_q),
      .y_i          (y_q),
      .latch_i      (latch),
      .match_o      (match[g]),
      .pend_min_o   (pend_min[g]),
      .pend_max_o   (pend_max[g]),
      .box_x_o      (box_x[g]),
      .box_y_o      (box_y[g]),
      .hit_o        (hit[g])
    );
  end

  always_comb begin
    status = '0;
    status[NUM_COLOURS-1:0] = hit;
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_COLOURS; i++) begin
      if (s_address == ADDR_W'(4 * i + int'(MIN)))   rdata_d = {8'h00, pend_min[i]};
      if (s_address == ADDR_W'(4 * i + int'(MAX)))   rdata_d = {8'h00, pend_max[i]};
      if (s_address == ADDR_W'(4 * i + int'(BOX_X))) rdata_d = box_x[i];
      if (s_address == ADDR_W'(4 * i + int'(BOX_Y))) rdata_d = box_y[i];
    end
    if (s_address == ADDR_W'(4 * NUM_COLOURS + STATUS))  rdata_d = {frame_cnt_q, 8'h00, status};
    if (s_address == ADDR_W'(4 * NUM_COLOURS + OVERLAY)) rdata_d = {8'h00, ovl_pend_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_data_q  <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      vid_pkt_q   <= 1'b0;
      mode_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      ovl_pend_q  <= 24'hFFFFFF;
      ovl_act_q   <= 24'hFFFFFF;
      frame_cnt_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        src_valid_q <= 1'b1;
        src_data_q  <= src_data_d;
        src_sop_q   <= sink_sop;
        src_eop_q   <= sink_eop;
      end else if (source_ready) begin
        src_valid_q <= 1'b0;
      end
      if (accept && sink_sop) begin
        vid_pkt_q <= is_video_hdr;
        mode_q    <= mode;
      end else if (latch) begin
        vid_pkt_q <= 1'b0;
      end
      x_q <= x_d;
      y_q <= y_d;
      if (frame_start) ovl_act_q <= ovl_pend_q;
      if (s_write && (s_address == ADDR_W'(4 * NUM_COLOURS + OVERLAY)))
        ovl_pend_q <= s_writedata[23:0];
      if (latch) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (s_read) rdata_q <= rdata_d;
    end
  end

  assign source_data  = src_data_q;
  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign s_readdata   = rdata_q;
endmodule

// File: tb/tb_multi_colour_bbox.sv
// Scoreboard bench for multi_colour_bbox on a reduced 64x16 image.
module tb_multi_colour_bbox;
  localparam int N = 4, W = 64, H = 16, AW = 5;
  localparam int STAT_A = 4 * N, OVL_A = 4 * N + 1;

  logic          clk = 0, reset_n = 0, mode = 0;
  logic [23:0]   sink_data = '0;
  logic          sink_valid = 0, sink_sop = 0, sink_eop = 0, sink_ready;
  logic [23:0]   source_data;
  logic          source_valid, source_sop, source_eop;
  logic          source_ready = 1;
  logic [AW-1:0] s_address = '0;
  logic          s_read = 0, s_write = 0;
  logic [31:0]   s_writedata = '0, s_readdata;

  always #5 clk = ~clk;

  multi_colour_bbox #(.NUM_COLOURS(N), .IMAGE_W(W), .IMAGE_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid), .source_sop(source_sop),
    .source_eop(source_eop), .source_ready(source_ready),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  int errors = 0, checks = 0;
  typedef struct packed { logic [23:0] d; logic sop; logic eop; } beat_t;
  beat_t exp_q[$];
  beat_t mon_e;
  bit stall_en = 0;

  // Reference model state
  logic [23:0] m_pmin[N], m_pmax[N], m_amin[N], m_amax[N];
  logic [23:0] m_povl, m_aovl;
  logic [31:0] m_bx[N], m_by[N];
  logic [7:0]  m_status;
  logic [15:0] m_fc;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pmin[i] = 24'h000000; m_pmax[i] = 24'hFFFFFF;
      m_bx[i] = '0; m_by[i] = '0;
    end
    m_povl = 24'hFFFFFF; m_status = '0; m_fc = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Stream monitor: pops one expected beat per output transfer
  always @(negedge clk) begin
    if (reset_n && source_valid && source_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got beat %h with nothing expected", source_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({source_data, source_sop, source_eop} !== mon_e) begin
          errors++;
          $display("FAIL stream_beat: got %h sop=%0b eop=%0b expected %h sop=%0b eop=%0b",
                   source_data, source_sop, source_eop, mon_e.d, mon_e.sop, mon_e.eop);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      source_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop,
                           input logic [23:0] exp_d);
    bit done = 0;
    sink_data = d; sink_sop = sop; sink_eop = eop; sink_valid = 1;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      if (sink_ready) begin
        exp_q.push_back({exp_d, sop, eop});
        done = 1;
      end
      @(posedge clk); #1;
    end
    sink_valid = 0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic mm_write(input int a, input logic [31:0] d);
    s_address = AW'(a); s_writedata = d; s_write = 1;
    @(posedge clk); #1;
    s_write = 0;
  endtask

  task automatic mm_read(input int a, output logic [31:0] d);
    s_address = AW'(a); s_read = 1;
    @(posedge clk); #1;
    s_read = 0;
    d = s_readdata;
  endtask

  task automatic chk_reg(input string name, input int a, input logic [31:0] exp);
    logic [31:0] v;
    mm_read(a, v);
    chk(name, v, exp);
  endtask

  task automatic set_thr(input int i, input logic [23:0] lo, input logic [23:0] hi);
    mm_write(4 * i, {8'h00, lo});
    mm_write(4 * i + 1, {8'h00, hi});
    m_pmin[i] = lo; m_pmax[i] = hi;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic bit in_win(logic [23:0] p, logic [23:0] lo, logic [23:0] hi);
    for (int c = 0; c < 3; c++)
      if (p[c*8 +: 8] < lo[c*8 +: 8] || p[c*8 +: 8] > hi[c*8 +: 8]) return 0;
    return 1;
  endfunction

  // Scene 0: red block (10..20, 5..7) and blue block (30..33, 9..12); scene 1: background only
  function automatic logic [23:0] scene_px(input int scene, input int x, input int y);
    if (scene == 0 && x >= 10 && x <= 20 && y >= 5 && y <= 7) return 24'hFF0000;
    if (scene == 0 && x >= 30 && x <= 33 && y >= 9 && y <= 12) return 24'h0000FF;
    return 24'($urandom) & 24'h7F7F7F;
  endfunction

  task automatic run_frame(input int scene, input bit midwrite, input int extra);
    int xmn[N], xmx[N], ymn[N], ymx[N];
    bit seen[N];
    bit m_mode, any;
    logic [23:0] px, o;
    int x, y;
    for (int i = 0; i < N; i++) begin
      m_amin[i] = m_pmin[i]; m_amax[i] = m_pmax[i]; seen[i] = 0;
      xmn[i] = 0; xmx[i] = 0; ymn[i] = 0; ymx[i] = 0;
    end
    m_aovl = m_povl;
    m_mode = mode;
    send_beat(24'h000000, 1, 0, 24'h000000);
    for (int p = 0; p < W * H + extra; p++) begin
      x = p % W; y = p / W;
      px = scene_px(scene, x, y);
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (y < H && in_win(px, m_amin[i], m_amax[i])) begin
          any = 1;
          if (!seen[i]) begin
            xmn[i] = x; xmx[i] = x; ymn[i] = y; ymx[i] = y;
          end else begin
            if (x < xmn[i]) xmn[i] = x;
            if (x > xmx[i]) xmx[i] = x;
            if (y < ymn[i]) ymn[i] = y;
            if (y > ymx[i]) ymx[i] = y;
          end
          seen[i] = 1;
        end
      end
      o = (m_mode && any) ? m_aovl : px;
      if (midwrite && p == (W * H) / 2) set_thr(1, 24'h0000FF, 24'h0000FF);
      send_beat(px, 0, p == W * H + extra - 1, o);
    end
    for (int i = 0; i < N; i++) begin
      m_bx[i] = seen[i] ? {16'(xmx[i]), 16'(xmn[i])} : 32'h0;
      m_by[i] = seen[i] ? {16'(ymx[i]), 16'(ymn[i])} : 32'h0;
      m_status[i] = seen[i];
    end
    m_fc++;
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < N; i++) begin
      chk_reg($sformatf("%s_box_x%0d", tag, i), 4 * i + 2, m_bx[i]);
      chk_reg($sformatf("%s_box_y%0d", tag, i), 4 * i + 3, m_by[i]);
    end
    chk_reg({tag, "_status"}, STAT_A, {m_fc, 8'h00, m_status});
  endtask

  logic [31:0] rv;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    chk("rst_source_valid", 32'(source_valid), 32'd0);
    chk("rst_source_data", 32'(source_data), 32'd0);
    chk("rst_readdata", s_readdata, 32'd0);
    chk_reg("rst_status", STAT_A, 32'h0);
    for (int i = 0; i < N; i++) begin
      chk_reg("rst_box_x", 4 * i + 2, 32'h0);
      chk_reg("rst_box_y", 4 * i + 3, 32'h0);
    end
    chk_reg("rst_min0", 0, 32'h0);
    chk_reg("rst_max0", 1, 32'h00FFFFFF);
    chk_reg("rst_overlay", OVL_A, 32'h00FFFFFF);
    chk_reg("unmapped", 31, 32'h0);

    set_thr(0, 24'hFF0000, 24'hFF0000);
    for (int i = 1; i < N; i++) set_thr(i, 24'hFFFFFF, 24'h000000);
    chk_reg("pend_min0", 0, 32'h00FF0000);
    mm_write(2, 32'hDEADBEEF);
    chk_reg("ro_write_ignored", 2, 32'h0);

    // Red block, pass-through
    run_frame(0, 0, 0);
    drain();
    check_frame("red");
    chk_reg("red_box_x_const", 2, 32'h0014000A);
    chk_reg("red_box_y_const", 3, 32'h00070005);
    chk_reg("red_status_const", STAT_A, 32'h00010001);

    // Same scene under random backpressure
    stall_en = 1;
    run_frame(0, 0, 0);
    drain();
    stall_en = 0;
    check_frame("stall");
    chk_reg("stall_box_x_const", 2, 32'h0014000A);

    // Overlay recolouring of the red block
    mm_write(OVL_A, 32'h0000FF00);
    m_povl = 24'h00FF00;
    chk_reg("overlay_pending", OVL_A, 32'h0000FF00);
    mode = 1;
    run_frame(0, 0, 0);
    drain();
    mode = 0;
    check_frame("ovl");

    // Colour 1 thresholds written mid-frame take effect on the next frame only
    run_frame(0, 1, 0);
    drain();
    check_frame("midwr");
    chk_reg("midwr_pending_min1", 4, 32'h000000FF);
    mm_read(STAT_A, rv);
    chk("midwr_bit1_clear", 32'(rv[1]), 32'd0);
    run_frame(0, 0, 0);
    drain();
    check_frame("next");
    mm_read(STAT_A, rv);
    chk("next_bit1_set", 32'(rv[1]), 32'd1);

    // Wide dark window, overlay, stalls, plus an extra line beyond the image height
    set_thr(2, 24'h000000, 24'h303030);
    mode = 1; stall_en = 1;
    run_frame(0, 0, W);
    drain();
    mode = 0; stall_en = 0;
    check_frame("wide");

    // Control packet must not latch; then a video frame with no matches
    set_thr(2, 24'hFFFFFF, 24'h000000);
    send_beat(24'h00000F, 1, 0, 24'h00000F);
    for (int k = 0; k < 5; k++) begin
      logic [23:0] d;
      d = 24'($urandom);
      send_beat(d, 0, k == 4, d);
    end
    drain();
    check_frame("ctrl");
    run_frame(1, 0, 0);
    drain();
    check_frame("nomatch");

    // Reset in the middle of a frame discards everything
    send_beat(24'h000000, 1, 0, 24'h000000);
    for (int p = 0; p < 100; p++) begin
      logic [23:0] d;
      d = scene_px(0, p % W, p / W);
      send_beat(d, 0, 0, d);
    end
    reset_n = 0;
    #1;
    exp_q.delete();
    chk("midrst_source_valid", 32'(source_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
    chk_reg("midrst_status", STAT_A, 32'h0);
    chk_reg("midrst_box_x0", 2, 32'h0);
    chk_reg("midrst_min0", 0, 32'h0);
    chk_reg("midrst_max0", 1, 32'h00FFFFFF);
    chk_reg("midrst_overlay", OVL_A, 32'h00FFFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
